// File: rtl/unpool_pkg.sv
// Shared constants, state encoding and kernel-size helpers for the unpool
// (nearest-neighbour upsampler) stage.
package unpool_pkg;

  localparam int MAT_MUL_SIZE  = 4;
  localparam int DWIDTH        = 8;
  localparam int MAX_BITS_POOL = 3;

  localparam int ROW_BITS = MAT_MUL_SIZE * DWIDTH;
  localparam int LOG_M    = $clog2(MAT_MUL_SIZE);
  localparam int BEAT_W   = (LOG_M > 0) ? LOG_M : 1;
  localparam int ROW_W    = LOG_M + 1;

  typedef logic [MAX_BITS_POOL-1:0] kernel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Legal factors are non-zero powers of two no wider than a row.
  function automatic logic kernel_legal(input kernel_t k);
    return (k != '0) && ((k & (k - kernel_t'(1))) == '0) && (int'(k) <= MAT_MUL_SIZE);
  endfunction

  function automatic kernel_t kernel_sanitize(input kernel_t k);
    return kernel_legal(k) ? k : kernel_t'(1);
  endfunction

  function automatic int kernel_log2(input kernel_t k);
    int r;
    r = 0;
    for (int i = 0; i < MAX_BITS_POOL; i++) begin
      if (k[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/unpool_replicate.sv
// Combinational element fan-out: builds output beat b of a held row, where
// output element j takes hold[b*(MAT_MUL_SIZE/k) + j/k].
module unpool_replicate
  import unpool_pkg::*;
(
  input  logic [ROW_BITS-1:0]      hold_i,
  input  logic [BEAT_W-1:0]        beat_i,
  input  logic [MAX_BITS_POOL-1:0] k_i,
  output logic [ROW_BITS-1:0]      data_o
);

  int                lg;
  logic [BEAT_W-1:0] src;

  // k_i is always a sanitized power of two, so divisions reduce to shifts.
  always_comb begin
    data_o = '0;
    lg     = kernel_log2(k_i);
    src    = '0;
    for (int j = 0; j < MAT_MUL_SIZE; j++) begin
      src = BEAT_W'(((int'(beat_i) << LOG_M) >> lg) + (j >> lg));
      data_o[j*DWIDTH +: DWIDTH] = hold_i[int'(src)*DWIDTH +: DWIDTH];
    end
  end

endmodule

// File: rtl/unpool.sv
// Nearest-neighbour upsampler: accepts pooled rows and emits kernel_size
// replicated full-width rows per input row, with a combinational bypass.
module unpool
  import unpool_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable_unpool,
  input  logic [MAX_BITS_POOL-1:0] kernel_size,
  input  logic [ROW_BITS-1:0]      inp_data,
  input  logic                     in_data_available,
  output logic                     in_ready,
  output logic [ROW_BITS-1:0]      out_data,
  output logic                     out_data_available,
  input  logic                     out_ready,
  output logic                     done_unpool
);

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] hold_q, hold_d;
  kernel_t             k_q, k_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ROW_W-1:0]    row_q, row_d;

  logic                last_beat, row_room, ready_int, accept;
  logic [ROW_BITS-1:0] rep_data;

  // Disabling the block clears it exactly like reset, discarding any open row.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk) begin
    if (reset || !enable_unpool) begin
      state_q <= IDLE;
      hold_q  <= '0;
      k_q     <= kernel_t'(1);
      beat_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    k_d       = k_q;
    beat_d    = beat_q;
    row_d     = row_q;
    last_beat = (int'(beat_q) == int'(k_q) - 1);
    row_room  = (int'(row_q) + 1 < MAT_MUL_SIZE);
    ready_int = (state_q == IDLE) ||
                (state_q == EXPAND && out_ready && last_beat && row_room);
    accept    = in_data_available && ready_int;

    case (state_q)
      EXPAND: begin
        if (out_ready) begin
          if (!last_beat) begin
            beat_d = beat_q + BEAT_W'(1);
          end else begin
            row_d = row_q + ROW_W'(1);
            if (!accept) state_d = row_room ? IDLE : DONE;
          end
        end
      end
      default: ;
    endcase

    // A reload on the final beat keeps the stream bubble-free.
    if (accept) begin
      hold_d  = inp_data;
      k_d     = kernel_sanitize(kernel_size);
      beat_d  = '0;
      state_d = EXPAND;
    end
  end

  unpool_replicate u_replicate (
    .hold_i (hold_q),
    .beat_i (beat_q),
    .k_i    (k_q),
    .data_o (rep_data)
  );

  assign in_ready           = enable_unpool ? ready_int : out_ready;
  assign out_data_available = enable_unpool ? (state_q == EXPAND) : in_data_available;
  assign out_data           = enable_unpool ? rep_data : inp_data;
  assign done_unpool        = enable_unpool ? (state_q == DONE) : 1'b1;

endmodule
